uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Parametrised asynchronous-serial receiver; next generation of the fixed 8N1 receiver.
- Configurable data width, optional parity and one or two stop bits.
- Adds an input synchroniser, start-bit glitch rejection, and parity/framing error flags.
- Sits between the host serial pin and the command/work-loading logic; emits one word per received frame.

Parameters:
- CLK_PER_BIT, 50, clk cycles per serial bit (must be ≥ 4).
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- SYNC_STAGES, 2, flops in the rx synchroniser (≥ 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- rx  in  1  raw serial line; idle high.
- data  out  DATA_BITS  last received word, LSB = first data bit on the line.
- new_data  out  1  one-cycle pulse; a frame completed.
- parity_err  out  1  valid with new_data; parity mismatch. Always 0 when PARITY=0.
- frame_err  out  1  valid with new_data; a stop bit was sampled low.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - data = 0; new_data, parity_err, frame_err = 0; busy = 0.
  - State = IDLE; counters = 0.
  - Synchroniser flops = 1, so no false start bit occurs at reset release.
- Synchroniser:
  - rx passes through SYNC_STAGES flops; the output is rx_s.
  - All decisions use rx_s. Pin-to-rx_s latency is SYNC_STAGES cycles.
- Bit counter: ctr has width $clog2(CLK_PER_BIT). It is cleared on every state entry and on every bit sample.
- States:
  - IDLE: ctr = 0, bit_idx = 0. If rx_s == 0, go to START.
  - START: ctr increments. When ctr == CLK_PER_BIT>>1 (mid start bit):
    - rx_s == 1: glitch; return to IDLE with no output.
    - rx_s == 0: ctr = 0; go to DATA.
  - DATA: ctr increments. When ctr == CLK_PER_BIT-1, sample rx_s:
    - Shift it into the data shift register MSB-side (LSB-first reception).
    - Increment bit_idx.
    - On sample DATA_BITS-1: go to PARITY if PARITY != 0, else to STOP.
  - PARITY: one bit period, same sampling. Store the sampled bit.
    - Odd mode: error if XOR(data bits, parity bit) == 0.
    - Even mode: error if that XOR == 1.
  - STOP: STOP_BITS periods, same sampling. A sticky stop_low bit is set if any stop sample is 0.
    - At the last stop sample, the registered outputs on the next edge are:
      - new_data = 1 for exactly one cycle.
      - data = shift register.
      - parity_err = computed result.
      - frame_err = stop_low | (current sample == 0).
    - Next state: WAIT_HIGH if the last stop sample is 0, else IDLE.
  - WAIT_HIGH: hold until rx_s == 1, then go to IDLE. This handles break conditions without re-triggering every bit time.
- Output holding:
  - data holds its value until the next frame completes.
  - parity_err and frame_err are valid only in the new_data cycle and are 0 otherwise.
- new_data pulses for every completed frame, including errored ones. The consumer qualifies it with the error flags.
- Latency: new_data rises 1 cycle after the clk edge that samples the final stop bit.
- Next frame: a start edge arriving the cycle after a good stop sample is accepted, because IDLE is entered immediately.
- Reset mid-frame: immediate return to reset values. A partial frame is discarded with no pulse.
- No overrun tracking. The consumer must take data within one frame time.

Decomposition:
- Shared package: state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; 3-bit) and parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
- Sub-module: sync_ff (SYNC_STAGES-deep bit synchroniser, async reset to a parametrised value). It is reused by other clock-crossing inputs.

Test Plan:
- 8N1 loopback (CLK_PER_BIT=16): send 0xA5 → one new_data pulse, data=0xA5, parity_err=0, frame_err=0, pulse 1 cycle after the stop-bit sample edge.
- Even parity (DATA_BITS=7, PARITY=2):
  - Send 0x41 with parity bit 0 → parity_err=0.
  - Resend 0x41 with parity bit 1 → parity_err=1, data=0x41.
- Glitch rejection: drive rx low for 5 cycles (< CLK_PER_BIT/2) → busy returns to 0, no new_data pulse. Then a valid 0x3C is received correctly.
- Break/framing: hold rx low for 12 bit times → one new_data with data=0x00 and frame_err=1. No further pulse until rx returns high and a new frame is sent.
- Two stop bits (STOP_BITS=2): send 0x55 with the second stop bit low → frame_err=1. Back-to-back frames 0x01, 0xFF with no idle gap → two pulses, correct data each.
- Async reset asserted mid-DATA (after 3 data bits) → all outputs 0 immediately, no pulse. The next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_frame_pkg.sv
// ============================================================================
// Module   : uart_rx_frame_pkg
// Purpose  : Shared receiver state encoding, parity modes and parity check.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_rx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // ones_xor is the XOR over the data bits and the received parity bit
    function automatic logic parity_error(input logic ones_xor, input int mode);
        if (mode == PAR_ODD) begin
            return ~ones_xor;
        end else if (mode == PAR_EVEN) begin
            return ones_xor;
        end
        return 1'b0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_frame_if.sv
// ============================================================================
// Module   : uart_rx_frame_if
// Purpose  : Serial line in, received word and status out of the receiver.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 new_data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx,
        output data,
        output new_data,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  new_data,
        input  parity_err,
        input  frame_err,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_frame_sync_ff.sv
// ============================================================================
// Module   : sync_ff
// Purpose  : STAGES-deep single-bit synchroniser, async reset to RESET_VAL.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : Parametrised async-serial receiver with glitch rejection and
//            parity / framing error flags; one word per completed frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int CLK_PER_BIT = 50,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_frame_if.master   bus_io
);
    localparam int CTR_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CTR_W-1:0] C_BIT_LAST  = CTR_W'(CLK_PER_BIT - 1);
    localparam logic [CTR_W-1:0] C_HALF      = CTR_W'(CLK_PER_BIT >> 1);
    localparam logic [IDX_W-1:0] C_DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] C_STOP_LAST = IDX_W'(STOP_BITS - 1);

    state_e               state_q, state_d;
    logic [CTR_W-1:0]     ctr_q, ctr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 stop_low_q, stop_low_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 new_data_q, new_data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;

    logic w_rx_s;
    logic w_bit_done;
    logic w_par_err;

    // Reset high so the line looks idle while reset releases
    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus_io.rx),
        .q_o (w_rx_s)
    );

    assign w_bit_done = (ctr_q == C_BIT_LAST);
    assign w_par_err  = parity_error(^{shift_q, par_q}, PARITY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ctr_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_low_q <= 1'b0;
            data_q     <= '0;
            new_data_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop_low_q <= stop_low_d;
            data_q     <= data_d;
            new_data_q <= new_data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_low_d = stop_low_q;
        data_d     = data_q;
        new_data_d = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ctr_d      = '0;
                idx_d      = '0;
                stop_low_d = 1'b0;
                if (!w_rx_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                // Start bit must still be low at its midpoint, else it was a glitch
                if (ctr_q == C_HALF) begin
                    ctr_d   = '0;
                    state_d = w_rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end

            ST_DATA: begin
                if (w_bit_done) begin
                    ctr_d   = '0;
                    shift_d = {w_rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == C_DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end

            ST_PARITY: begin
                if (w_bit_done) begin
                    ctr_d   = '0;
                    par_d   = w_rx_s;
                    state_d = ST_STOP;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end

            ST_STOP: begin
                if (w_bit_done) begin
                    ctr_d = '0;
                    if (idx_q == C_STOP_LAST) begin
                        idx_d      = '0;
                        new_data_d = 1'b1;
                        data_d     = shift_q;
                        perr_d     = w_par_err;
                        ferr_d     = stop_low_q | ~w_rx_s;
                        // A low final stop bit may be a break; wait for the line to recover
                        state_d    = w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        stop_low_d = stop_low_q | ~w_rx_s;
                        idx_d      = idx_q + IDX_W'(1);
                    end
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end

            ST_WAIT_HIGH: begin
                ctr_d = '0;
                if (w_rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ctr_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign bus_io.data       = data_q;
    assign bus_io.new_data   = new_data_q;
    assign bus_io.parity_err = perr_q;
    assign bus_io.frame_err  = ferr_q;
    assign bus_io.busy       = (state_q != ST_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
// Module   : tb_uart_rx_frame
// Purpose  : Directed bench for uart_rx_frame: 8N1, 7E1 and 8N2 instances
//            sharing one serial line; table of frames plus corner sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_frame;
    localparam int CPB = 16;

    logic clk;
    logic rst;
    logic rx;
    int   cyc;

    uart_rx_frame_if #(.DATA_BITS(8)) if_a ();
    uart_rx_frame_if #(.DATA_BITS(7)) if_b ();
    uart_rx_frame_if #(.DATA_BITS(8)) if_c ();

    assign if_a.rx = rx;
    assign if_b.rx = rx;
    assign if_c.rx = rx;

    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2))
        dut_a (.clk(clk), .rst(rst), .bus_io(if_a));
    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2))
        dut_b (.clk(clk), .rst(rst), .bus_io(if_b));
    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2))
        dut_c (.clk(clk), .rst(rst), .bus_io(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int         stray = 0;
    int         pulse_cyc_a = 0;
    logic [8:0] last_d[3];
    logic       last_pe[3];
    logic       last_fe[3];
    logic [8:0] q_c[$];

    // Capture each pulse mid-cycle; flags outside a pulse are counted as stray
    always @(negedge clk) begin
        if (if_a.new_data) begin
            cnt_a++; pulse_cyc_a = cyc;
            last_d[0] = {1'b0, if_a.data}; last_pe[0] = if_a.parity_err; last_fe[0] = if_a.frame_err;
        end else if (if_a.parity_err || if_a.frame_err) stray++;
        if (if_b.new_data) begin
            cnt_b++;
            last_d[1] = {2'b0, if_b.data}; last_pe[1] = if_b.parity_err; last_fe[1] = if_b.frame_err;
        end else if (if_b.parity_err || if_b.frame_err) stray++;
        if (if_c.new_data) begin
            cnt_c++;
            last_d[2] = {1'b0, if_c.data}; last_pe[2] = if_c.parity_err; last_fe[2] = if_c.frame_err;
            q_c.push_back({1'b0, if_c.data});
        end else if (if_c.parity_err || if_c.frame_err) stray++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int get_cnt(input int sel);
        return (sel == 0) ? cnt_a : (sel == 1) ? cnt_b : cnt_c;
    endfunction

    // sel 0: 8N1, sel 1: 7E1 (par = parity bit), sel 2: 8N2
    task automatic build(input int sel, input logic [8:0] d, input logic par, input logic s1,
                         input logic s2, output logic [15:0] bits, output int n);
        bits = '1;
        case (sel)
            0:       begin bits[9:0]  = {s1, d[7:0], 1'b0};      n = 10; end
            1:       begin bits[9:0]  = {s1, par, d[6:0], 1'b0}; n = 10; end
            default: begin bits[10:0] = {s2, s1, d[7:0], 1'b0};  n = 11; end
        endcase
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int nbits);
        rx = 1'b1;
        repeat (nbits * CPB) @(negedge clk);
    endtask

    typedef struct {
        int         sel;
        logic [8:0] d;
        logic       par;
        logic       s1;
        logic       s2;
        logic [8:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t        vecs[8];
    logic [15:0] bits;
    int          nb;
    int          prev;
    int          c0;
    int          qs;

    initial begin
        vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h033, 1'b0, 1'b0, 1'b1, 9'h033, 1'b0, 1'b1};
        vecs[3] = '{1, 9'h041, 1'b0, 1'b1, 1'b1, 9'h041, 1'b0, 1'b0};
        vecs[4] = '{1, 9'h041, 1'b1, 1'b1, 1'b1, 9'h041, 1'b1, 1'b0};
        vecs[5] = '{1, 9'h07F, 1'b1, 1'b1, 1'b1, 9'h07F, 1'b0, 1'b0};
        vecs[6] = '{2, 9'h055, 1'b0, 1'b1, 1'b0, 9'h055, 1'b0, 1'b1};
        vecs[7] = '{2, 9'h081, 1'b0, 1'b1, 1'b1, 9'h081, 1'b0, 1'b0};

        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset data", {24'd0, if_a.data}, 32'h0);
        check("reset busy", {31'd0, if_a.busy}, 32'h0);
        check("reset new_data", {31'd0, if_a.new_data}, 32'h0);
        check("reset flags", {30'd0, if_a.parity_err, if_a.frame_err}, 32'h0);
        rst = 1'b0;
        idle(2);
        check("no start after reset", {31'd0, if_a.busy}, 32'h0);
        check("no pulse after reset", cnt_a, 0);

        // Pulse lands 2 sync + 1 detect + 9 half-bit + 9 bit periods after the first edge seeing rx low
        prev = cnt_a;
        c0   = cyc;
        build(0, 9'h0A5, 1'b0, 1'b1, 1'b1, bits, nb);
        send_bits(bits, nb);
        idle(3);
        check("8N1 pulse count", cnt_a - prev, 1);
        check("8N1 data", {23'd0, last_d[0]}, 32'h0A5);
        check("8N1 flags", {30'd0, last_pe[0], last_fe[0]}, 32'h0);
        check("8N1 latency", pulse_cyc_a, c0 + 1 + 2 + 9 + 9 * CPB);

        for (int i = 0; i < 8; i++) begin
            prev = get_cnt(vecs[i].sel);
            build(vecs[i].sel, vecs[i].d, vecs[i].par, vecs[i].s1, vecs[i].s2, bits, nb);
            send_bits(bits, nb);
            idle(3);
            check($sformatf("vec%0d pulses", i), get_cnt(vecs[i].sel) - prev, 1);
            check($sformatf("vec%0d data", i), {23'd0, last_d[vecs[i].sel]}, {23'd0, vecs[i].exp_d});
            check($sformatf("vec%0d parity_err", i), {31'd0, last_pe[vecs[i].sel]}, {31'd0, vecs[i].exp_pe});
            check($sformatf("vec%0d frame_err", i), {31'd0, last_fe[vecs[i].sel]}, {31'd0, vecs[i].exp_fe});
        end

        // Glitch: 5 low cycles, shorter than half a bit
        prev = cnt_a;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch busy", {31'd0, if_a.busy}, 32'h1);
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch idle", {31'd0, if_a.busy}, 32'h0);
        check("glitch no pulse", cnt_a - prev, 0);
        build(0, 9'h03C, 1'b0, 1'b1, 1'b1, bits, nb);
        send_bits(bits, nb);
        idle(3);
        check("after glitch pulses", cnt_a - prev, 1);
        check("after glitch data", {23'd0, last_d[0]}, 32'h03C);

        // Break: line low for 12 bit times
        prev = cnt_a;
        rx = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("break pulses", cnt_a - prev, 1);
        check("break data", {23'd0, last_d[0]}, 32'h0);
        check("break frame_err", {31'd0, last_fe[0]}, 32'h1);
        check("break held busy", {31'd0, if_a.busy}, 32'h1);
        idle(2);
        check("break released", {31'd0, if_a.busy}, 32'h0);
        check("break single pulse", cnt_a - prev, 1);
        build(0, 9'h05A, 1'b0, 1'b1, 1'b1, bits, nb);
        send_bits(bits, nb);
        idle(3);
        check("after break pulses", cnt_a - prev, 2);
        check("after break data", {23'd0, last_d[0]}, 32'h05A);
        check("after break frame_err", {31'd0, last_fe[0]}, 32'h0);

        // Back-to-back 8N2 frames with no idle gap
        prev = cnt_c;
        qs   = q_c.size();
        build(2, 9'h001, 1'b0, 1'b1, 1'b1, bits, nb);
        send_bits(bits, nb);
        build(2, 9'h0FF, 1'b0, 1'b1, 1'b1, bits, nb);
        send_bits(bits, nb);
        idle(3);
        check("b2b pulses", cnt_c - prev, 2);
        if (q_c.size() >= qs + 2) begin
            check("b2b first", {23'd0, q_c[qs]}, 32'h001);
            check("b2b second", {23'd0, q_c[qs + 1]}, 32'h0FF);
        end

        // Reset after the start bit and three data bits
        prev = cnt_a;
        build(0, 9'h081, 1'b0, 1'b1, 1'b1, bits, nb);
        send_bits(bits, 4);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        check("midreset data", {24'd0, if_a.data}, 32'h0);
        check("midreset busy", {31'd0, if_a.busy}, 32'h0);
        check("midreset outputs", {29'd0, if_a.new_data, if_a.parity_err, if_a.frame_err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);
        check("midreset no pulse", cnt_a - prev, 0);
        send_bits(bits, nb);
        idle(3);
        check("after reset pulses", cnt_a - prev, 1);
        check("after reset data", {23'd0, last_d[0]}, 32'h081);
        check("after reset frame_err", {31'd0, last_fe[0]}, 32'h0);

        check("stray flags", stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
